restoring_divider: RTL

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 12 +
 rtl/restoring_divider_div_step.sv | 29 ++
 rtl/restoring_divider.sv | 138 +++++++++++++
 3 files changed

// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared state encoding and default width for restoring_divider
package restoring_divider_pkg;

    localparam int DEFAULT_N = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_div_step.sv
// rtl/restoring_divider_div_step.sv - one combinational restoring-division step
//
// Ports:
//   rem_in   [N:0]   partial remainder before the step (always < divisor)
//   divisor  [N-1:0] divisor
//   bit_in           next dividend bit, MSB first
//   rem_out  [N:0]   partial remainder after shift and conditional subtract
//   q_bit            quotient bit produced by this step
module div_step #(
    parameter int N = 5
) (
    input  logic [N:0]   rem_in,
    input  logic [N-1:0] divisor,
    input  logic         bit_in,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N:0]   trial;

    assign shifted = {rem_in, bit_in};
    // The difference is only used when shifted >= divisor, where it is below
    // 2*divisor and therefore fits in N+1 bits.
    assign trial   = shifted[N:0] - {1'b0, divisor};
    assign q_bit   = (shifted >= {2'b00, divisor});
    assign rem_out = q_bit ? trial : shifted[N:0];

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle unsigned restoring divider, 2N/N -> N quotient and remainder
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             level request, sampled in IDLE to launch a divide
//   dividend [2N-1:0] unsigned dividend
//   divisor  [N-1:0]  unsigned divisor
//   quotient [N-1:0]  registered quotient
//   remainder[N-1:0]  registered remainder
//   finish            high while results are presented (DONE)
//   div_by_zero       last launch had divisor == 0
//   overflow          last launch had a quotient wider than N bits
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           finish,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N + 1);

    state_t        state, state_nxt;
    logic [N:0]    rem_q;
    // Holds the not-yet-consumed dividend bits; quotient bits shift in from
    // the bottom as dividend bits leave the top, so it ends as the quotient.
    logic [N-1:0]  work_q;
    logic [N-1:0]  dvsr_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    step_rem;
    logic          step_q;
    logic [N-1:0]  work_nxt;
    logic          is_dbz;
    logic          is_ovf;
    logic          last_step;

    div_step #(.N(N)) u_step (
        .rem_in  (rem_q),
        .divisor (dvsr_q),
        .bit_in  (work_q[N-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign work_nxt  = {work_q[N-2:0], step_q};
    assign is_dbz    = (divisor == '0);
    assign is_ovf    = (dividend[2*N-1:N] >= divisor);
    assign last_step = (cnt_q == CW'(1));
    assign finish    = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (is_dbz || is_ovf) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // start must be seen low before another launch is possible
                if (!start) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            rem_q       <= '0;
            work_q      <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvsr_q      <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (is_dbz) begin
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                        end else if (is_ovf) begin
                            quotient  <= '1;
                            remainder <= '0;
                            overflow  <= 1'b1;
                        end else begin
                            rem_q  <= {1'b0, dividend[2*N-1:N]};
                            work_q <= dividend[N-1:0];
                            cnt_q  <= CW'(N);
                        end
                    end
                end
                ST_CALC: begin
                    rem_q  <= step_rem;
                    work_q <= work_nxt;
                    cnt_q  <= cnt_q - CW'(1);
                    if (last_step) begin
                        quotient  <= work_nxt;
                        remainder <= step_rem[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
